// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer:
// operand width, 4-bit ALU control codes and the sequencer state set.
package alu_pkg;

   localparam int XLEN = 64;

   localparam logic [3:0] OP_MUL   = 4'b1000;
   localparam logic [3:0] OP_MULU  = 4'b1001;
   localparam logic [3:0] OP_DIV   = 4'b1010;
   localparam logic [3:0] OP_DIVU  = 4'b1011;
   localparam logic [3:0] OP_REM   = 4'b1100;
   localparam logic [3:0] OP_REMU  = 4'b1101;
   localparam logic [3:0] OP_MULH  = 4'b1110;
   localparam logic [3:0] OP_MULHU = 4'b1111;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      CALC,
      FIX,
      DONE
   } state_e;

   function automatic logic op_is_div(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
   endfunction

   function automatic logic op_is_rem(input logic [3:0] op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

   function automatic logic op_is_signed(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM) || (op == OP_MULH);
   endfunction

endpackage

// File: rtl/muldiv_step_unit.sv
// One iteration of the shared datapath: a shift-add multiply step or a
// restoring-divide step on the {hi, lo} accumulator pair. Purely combinational.
module muldiv_step_unit #(
   parameter int XLEN = alu_pkg::XLEN
) (
   input  logic            is_div_i,
   input  logic [XLEN-1:0] hi_i,
   input  logic [XLEN-1:0] lo_i,
   input  logic [XLEN-1:0] b_i,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o
);

   logic [XLEN:0]   add_sum;
   logic [XLEN:0]   div_sh;
   logic [XLEN-1:0] div_diff;
   logic            div_ge;

   // Multiply: hi accumulates the partial product, lo holds the multiplier
   // and collects product bits shifted out of hi.
   assign add_sum = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);

   // Divide: hi is the partial remainder, lo shifts the dividend out and
   // the quotient bits in.
   assign div_sh   = {hi_i, lo_i[XLEN-1]};
   assign div_ge   = div_sh >= {1'b0, b_i};
   assign div_diff = div_sh[XLEN-1:0] - b_i;

   always_comb begin
      if (is_div_i) begin
         hi_o = div_ge ? div_diff : div_sh[XLEN-1:0];
         lo_o = {lo_i[XLEN-2:0], div_ge};
      end else begin
         hi_o = add_sum[XLEN:1];
         lo_o = {add_sum[0], lo_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle MUL/DIV/REM sequencer: accept, form magnitudes, iterate XLEN
// steps, sign-correct, then hold the result until the consumer takes it.
module alu_muldiv_sequencer
   import alu_pkg::*;
#(
   parameter int XLEN = alu_pkg::XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_valid,
   output logic            start_ready,
   input  logic [3:0]      alu_control,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   input  logic            flush,
   output logic            result_valid,
   input  logic            result_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   state_e          state_q, state_d;
   logic [3:0]      op_q, op_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] opb_q, opb_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [5:0]      cnt_q, cnt_d;
   logic            a_neg_q, a_neg_d;
   logic            res_neg_q, res_neg_d;
   logic            div_zero_q, div_zero_d;

   logic            is_div;
   logic [XLEN-1:0] step_hi, step_lo;

   assign is_div = op_is_div(op_q);

   muldiv_step_unit #(.XLEN(XLEN)) u_step (
      .is_div_i (is_div),
      .hi_i     (hi_q),
      .lo_i     (lo_q),
      .b_i      (opb_q),
      .hi_o     (step_hi),
      .lo_o     (step_lo)
   );

   // Magnitudes formed in PREP; the raw operands sit in lo_q / opb_q then.
   logic            a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;

   assign a_neg = op_is_signed(op_q) & lo_q[XLEN-1];
   assign b_neg = op_is_signed(op_q) & opb_q[XLEN-1];
   assign a_mag = a_neg ? -lo_q : lo_q;
   assign b_mag = b_neg ? -opb_q : opb_q;

   // Sign correction and field select used in FIX.
   logic [2*XLEN-1:0] prod_mag, prod_fix;
   logic [XLEN-1:0]   quot_fix, rem_fix, fix_value;

   assign prod_mag = {hi_q, lo_q};
   assign prod_fix = res_neg_q ? -prod_mag : prod_mag;
   assign quot_fix = div_zero_q ? '1 : (res_neg_q ? -lo_q : lo_q);
   assign rem_fix  = a_neg_q ? -hi_q : hi_q;

   always_comb begin
      case (op_q)
         OP_MUL, OP_MULU:   fix_value = prod_fix[XLEN-1:0];
         OP_MULH, OP_MULHU: fix_value = prod_fix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:   fix_value = quot_fix;
         OP_REM, OP_REMU:   fix_value = rem_fix;
         default:           fix_value = '0;
      endcase
   end

   always_comb begin
      // NOTE: every _d takes its _q value first, so a branch that does not
      // assign a register simply holds it and no latch can be inferred.
      state_d    = state_q;
      op_d       = op_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      opb_d      = opb_q;
      result_d   = result_q;
      cnt_d      = cnt_q;
      a_neg_d    = a_neg_q;
      res_neg_d  = res_neg_q;
      div_zero_d = div_zero_q;

      case (state_q)
         IDLE: begin
            if (start_valid && !flush) begin
               state_d = PREP;
               op_d    = alu_control;
               hi_d    = '0;
               lo_d    = operand_a;
               opb_d   = operand_b;
               cnt_d   = '0;
            end
         end
         PREP: begin
            lo_d       = a_mag;
            opb_d      = b_mag;
            a_neg_d    = a_neg;
            res_neg_d  = op_is_rem(op_q) ? a_neg : (a_neg ^ b_neg);
            div_zero_d = (opb_q == '0);
            state_d    = CALC;
         end
         CALC: begin
            hi_d = step_hi;
            lo_d = step_lo;
            if (cnt_q == 6'(XLEN-1)) begin
               cnt_d   = '0;
               state_d = FIX;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         FIX: begin
            result_d = fix_value;
            state_d  = DONE;
         end
         DONE: begin
            if (result_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Abort wins over both acceptance and the result handshake.
      if (flush && (state_q != IDLE)) begin
         state_d  = IDLE;
         cnt_d    = '0;
         result_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         op_q       <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         opb_q      <= '0;
         result_q   <= '0;
         cnt_q      <= '0;
         a_neg_q    <= 1'b0;
         res_neg_q  <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every register samples the values
         // from before this edge, independent of statement order.
         state_q    <= state_d;
         op_q       <= op_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         opb_q      <= opb_d;
         result_q   <= result_d;
         cnt_q      <= cnt_d;
         a_neg_q    <= a_neg_d;
         res_neg_q  <= res_neg_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign start_ready  = (state_q == IDLE);
   assign busy         = (state_q != IDLE);
   assign result_valid = (state_q == DONE);
   assign result       = result_q;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Self-checking bench for alu_muldiv_sequencer: directed corner cases,
// handshake/flush/reset scenarios and random ops against an arithmetic model.
module tb_alu_muldiv_sequencer;
   import alu_pkg::*;

   localparam int W = 64;
   localparam int LAT = W + 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start_valid = 1'b0;
   logic         start_ready;
   logic [3:0]   alu_control = '0;
   logic [W-1:0] operand_a = '0;
   logic [W-1:0] operand_b = '0;
   logic         flush = 1'b0;
   logic         result_valid;
   logic         result_ready = 1'b0;
   logic [W-1:0] result;
   logic         busy;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};
   localparam logic [W-1:0] ONES  = {W{1'b1}};

   always #5 clk = ~clk;

   alu_muldiv_sequencer #(.XLEN(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_valid  (start_valid),
      .start_ready  (start_ready),
      .alu_control  (alu_control),
      .operand_a    (operand_a),
      .operand_b    (operand_b),
      .flush        (flush),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .result       (result),
      .busy         (busy)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: observed time limit reached, required completion");
      $fatal(1, "simulation time limit");
   end

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: plain wide arithmetic with the architectural corner rules.
   function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      logic signed [2*W-1:0] sp;
      logic [2*W-1:0]        up;
      logic signed [W-1:0]   sa, sb;
      sa = a;
      sb = b;
      sp = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
      up = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      case (op)
         OP_MUL, OP_MULU: return up[W-1:0];
         OP_MULH:         return sp[2*W-1:W];
         OP_MULHU:        return up[2*W-1:W];
         OP_DIV: begin
            if (b == '0) return ONES;
            else if (a == MIN_V && b == ONES) return a;
            else return sa / sb;
         end
         OP_REM: begin
            if (b == '0) return a;
            else if (a == MIN_V && b == ONES) return '0;
            else return sa % sb;
         end
         OP_DIVU: return (b == '0) ? ONES : a / b;
         OP_REMU: return (b == '0) ? a : a % b;
         default: return '0;
      endcase
   endfunction

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(5))
         0:       return '0;
         1:       return ONES;
         2:       return MIN_V;
         3:       return W'($urandom_range(20));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic accept(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      start_valid = 1'b1;
      alu_control = op;
      operand_a   = a;
      operand_b   = b;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      alu_control = 4'($urandom);
      operand_a   = {$urandom, $urandom};
      operand_b   = {$urandom, $urandom};
   endtask

   task automatic wait_result(input string tag, input logic [W-1:0] exp);
      int lat;
      lat = 0;
      while (!result_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, " latency"}, W'(lat), W'(LAT));
      check({tag, " result"}, result, exp);
   endtask

   task automatic handshake(input string tag);
      result_ready = 1'b1;
      @(posedge clk);
      #1;
      result_ready = 1'b0;
      check({tag, " idle after handshake"}, W'(start_ready), W'(1));
   endtask

   task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp);
      accept(op, a, b);
      check({tag, " busy"}, W'(busy), W'(1));
      wait_result(tag, exp);
      handshake(tag);
   endtask

   task automatic expect_no_valid(input string tag, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (result_valid) seen = 1'b1;
      end
      check({tag, " no result_valid"}, W'(seen), W'(0));
   endtask

   initial begin
      logic [3:0]   op;
      logic [W-1:0] a, b;

      repeat (3) @(posedge clk);
      #1;
      check("reset result", result, '0);
      check("reset result_valid", W'(result_valid), W'(0));
      check("reset busy", W'(busy), W'(0));
      check("reset start_ready", W'(start_ready), W'(1));
      @(negedge clk);
      rst_n = 1'b1;

      run_op("mul 7*-3", OP_MUL, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB);
      run_op("mulhu ones", OP_MULHU, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE);
      run_op("mulh ones", OP_MULH, ONES, ONES, 64'd0);
      run_op("div -7/2", OP_DIV, -64'sd7, 64'd2, -64'sd3);
      run_op("rem -7%2", OP_REM, -64'sd7, 64'd2, ONES);
      run_op("divu 7/0", OP_DIVU, 64'd7, 64'd0, ONES);
      run_op("remu 7%0", OP_REMU, 64'd7, 64'd0, 64'd7);
      run_op("div -7/0", OP_DIV, -64'sd7, 64'd0, ONES);
      run_op("rem -7%0", OP_REM, -64'sd7, 64'd0, -64'sd7);
      run_op("div ovf", OP_DIV, MIN_V, ONES, MIN_V);
      run_op("rem ovf", OP_REM, MIN_V, ONES, 64'd0);
      run_op("code 0101", 4'b0101, 64'd9, 64'd4, 64'd0);

      // flush in IDLE blocks acceptance
      @(negedge clk);
      start_valid = 1'b1;
      flush       = 1'b1;
      alu_control = OP_MUL;
      @(posedge clk);
      #1;
      check("idle flush blocks accept", W'(busy), W'(0));
      start_valid = 1'b0;
      flush       = 1'b0;

      // result held while consumer stalls, then back-to-back after one idle cycle
      accept(OP_DIVU, 64'd100, 64'd7);
      wait_result("stall", 64'd14);
      for (int i = 0; i < 10; i++) begin
         check("stall result stable", result, 64'd14);
         check("stall start_ready", W'(start_ready), W'(0));
         check("stall result_valid", W'(result_valid), W'(1));
         @(posedge clk);
         #1;
      end
      handshake("stall");
      check("stall idle busy", W'(busy), W'(0));
      run_op("after stall", OP_MUL, 64'd3, 64'd5, 64'd15);

      // flush mid-CALC
      accept(OP_MUL, {$urandom, $urandom}, {$urandom, $urandom});
      repeat (31) @(posedge clk);
      #1;
      check("pre-flush busy", W'(busy), W'(1));
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush busy", W'(busy), W'(0));
      check("flush start_ready", W'(start_ready), W'(1));
      check("flush result_valid", W'(result_valid), W'(0));
      expect_no_valid("flush", 80);

      // asynchronous reset mid-CALC
      accept(OP_DIV, {$urandom, $urandom}, 64'd3);
      repeat (40) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("async rst busy", W'(busy), W'(0));
      check("async rst start_ready", W'(start_ready), W'(1));
      check("async rst result_valid", W'(result_valid), W'(0));
      check("async rst result", result, '0);
      @(negedge clk);
      rst_n = 1'b1;
      expect_no_valid("reset", 80);
      run_op("post reset", OP_REMU, 64'd23, 64'd5, 64'd3);

      for (int i = 0; i < 30; i++) begin
         op = 4'($urandom_range(15));
         if ($urandom_range(3) != 0) op[3] = 1'b1;
         a = pick_operand();
         b = pick_operand();
         run_op($sformatf("rand%0d op%b", i, op), op, a, b, model(op, a, b));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_muldiv_sequencer.md
ALU_MULDIV_SEQUENCER -- requirements
Module: alu_muldiv_sequencer

Interface
REQ-001 Parameter XLEN, default 64, operand and result width.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start_valid  input  1  request present.
REQ-005 start_ready  output  1  sequencer can accept a request.
REQ-006 alu_control  input  4  operation code: 1000 MUL, 1001 MULU, 1010 DIV, 1011 DIVU, 1100 REM, 1101 REMU, 1110 MULH, 1111 MULHU.
REQ-007 operand_a  input  XLEN  multiplicand or dividend.
REQ-008 operand_b  input  XLEN  multiplier or divisor.
REQ-009 flush  input  1  abort any operation in progress.
REQ-010 result_valid  output  1  result available.
REQ-011 result_ready  input  1  consumer takes result.
REQ-012 result  output  XLEN  operation result.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 States SHALL be IDLE, PREP, CALC, FIX and DONE; start_ready SHALL equal (state == IDLE).
REQ-015 Acceptance SHALL occur on an edge with start_valid && start_ready; alu_control and both operands SHALL be captured on that edge, and later input changes SHALL not affect the operation.
REQ-016 PREP (1 cycle) SHALL form operand magnitudes for signed codes (MUL, DIV, REM, MULH) and record the sign of operand_a and of the result.
REQ-017 CALC SHALL last exactly XLEN cycles, run one shift-add multiply step or one restoring-divide step per cycle, and use a 6-bit iteration counter that SHALL reach XLEN-1 and then exit to FIX.
REQ-018 FIX (1 cycle) SHALL apply the two's-complement sign correction and select the output field: low XLEN bits for MUL and MULU; high XLEN bits for MULH and MULHU; quotient for DIV and DIVU; remainder for REM and REMU.
REQ-019 Latency: result_valid SHALL rise 66 cycles (XLEN+2) after the acceptance edge for every code, including the corner cases.
REQ-020 Remainder sign SHALL follow the dividend; quotient sign SHALL be the XOR of the operand signs.
REQ-021 Divide by zero: quotient SHALL be all ones and remainder SHALL be the original operand_a, for both signed and unsigned codes.
REQ-022 Signed overflow (operand_a = most-negative value, operand_b = -1): DIV SHALL return operand_a and REM SHALL return 0.
REQ-023 Codes with alu_control[3] = 0 SHALL be accepted, follow the same timing, and return result 0.
REQ-024 In DONE, result_valid SHALL be 1 and result SHALL stay stable until result_ready is high; the next edge SHALL return the block to IDLE, so at least one idle cycle separates operations.
REQ-025 flush high on any edge outside IDLE SHALL return the block to IDLE with result_valid = 0 on the next cycle; flush SHALL take priority over acceptance and the result handshake.
REQ-026 flush in IDLE SHALL block acceptance on that edge.

Reset
REQ-027 rst_n low SHALL force, asynchronously, state = IDLE, result = 0, result_valid = 0, busy = 0, start_ready = 1 (once rst_n is released), iteration counter = 0 and all operand registers = 0.
REQ-028 Reset during CALC or DONE SHALL discard the operation with no result produced.

Structure
REQ-029 The shared package alu_pkg SHALL hold the 4-bit ALU control code constants, the state enumeration and XLEN.
REQ-030 One sub-module, muldiv_step_unit, SHALL hold the combinational per-iteration add/subtract-shift logic; the sequencer SHALL own all registers and the FSM.

Verification
REQ-031 MUL with a = 7, b = -3 -> result 0xFFFFFFFFFFFFFFEB, result_valid 66 cycles after acceptance.
REQ-032 MULHU with a = b = 0xFFFFFFFFFFFFFFFF -> result 0xFFFFFFFFFFFFFFFE; MULH with the same operands -> result 0.
REQ-033 DIV with a = -7, b = 2 -> result -3; REM with the same operands -> result -1; DIVU with a = 7, b = 0 -> result all ones; REMU with a = 7, b = 0 -> result 7.
REQ-034 DIV with a = 0x8000000000000000, b = -1 -> result 0x8000000000000000; REM with the same operands -> result 0.
REQ-035 result_ready held low for 10 cycles in DONE -> result stable, start_ready = 0; after the handshake, one IDLE cycle, then a new acceptance.
REQ-036 flush at CALC cycle 30, then rst_n pulsed low during a later CALC -> IDLE on the next cycle, no result_valid pulse, outputs at reset values.
